// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: PC owner, imem requester and prefetch FIFO.
// Define IFQ_PERF_EN to add the perf_fetched / perf_flushed counters.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;

    logic          acc;
    logic          rsp;
    logic          flush;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    // Handshakes, credit check and head-of-queue outputs
    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = (state == RUN) && (credit_used < DEPTH_W);
        imem_req_addr  = fetch_pc;
        acc            = imem_req_valid && imem_req_ready;
        rsp            = imem_rsp_valid;
        flush          = redirect_valid && (state == RUN);
        drop           = rsp && (flush || (discard != '0));
        push           = rsp && !drop;
        inst_valid     = (count != '0);
        pop            = inst_valid && inst_ready && !flush;
        inst_pc        = fifo_pc[rd_ptr];
        inst_data      = fifo_inst[rd_ptr];
    end

    // Leave IDLE on the first clock after reset and stay in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= RUN;
        end
    end

    // Fetch PC plus in-flight and stale-response counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (acc) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(acc) - CW'(rsp);
            // Stale words already counted in discard are still part of
            // outstanding, so after a flush everything in flight is stale.
            if (flush) begin
                discard <= outstanding + CW'(acc) - CW'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Prefetch FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Prefetch FIFO storage, tagged with the PC recorded at accept
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
            fifo_inst[wr_ptr] <= imem_rsp_data;
        end
    end

    // PC tag queue pointers: written on accept, retired on response
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (acc) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (rsp) begin
                tag_rd <= tag_rd + PW'(1);
            end
        end
    end

    // PC tag storage
    always_ff @(posedge clk) begin
        if (acc) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] flushed_now;

    // Work squashed this cycle: cleared entries plus dropped words
    always_comb begin
        flushed_now = (flush ? 32'(count) : 32'd0) + 32'(drop);
    end

    // Delivered and squashed instruction counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_flushed <= perf_flushed + flushed_now;
        end
    end
`endif

    // Credit rule keeps every push inside the FIFO; responses need a request
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (count == DEPTH_C)));
            assert (!(rsp && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue with an in-order memory model.
// Stimulus pushes expected pops; a monitor compares each delivered word.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .redirect_valid (redirect_valid),
`ifdef IFQ_PERF_EN
        .redirect_pc    (redirect_pc),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`else
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rel = 0;
    int lat = 1;

    logic [31:0] sb_pc [$];
    logic [31:0] sb_data [$];
    logic [31:0] acc_addr [$];
    logic [31:0] acc_cyc [$];
    logic [31:0] pop_cyc [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];

    function automatic logic [31:0] memdat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb_pc.push_back(pc);
        sb_data.push_back(memdat(pc));
    endtask

    // Memory model: in-order responses lat cycles after accept
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                imem_rsp_valid = 1'b0;
                pend_addr.delete();
                pend_due.delete();
            end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memdat(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            #1;
            if (!reset && imem_req_valid && imem_req_ready) begin
                acc_addr.push_back(imem_req_addr);
                acc_cyc.push_back(32'(cyc));
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
            end
        end
    end

    // Monitor: compare every delivered instruction with the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset && inst_valid && inst_ready && !redirect_valid) begin
                pop_cyc.push_back(32'(cyc));
                if (sb_pc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop got pc %h want none", inst_pc);
                end else begin
                    check("pop_pc", inst_pc, sb_pc.pop_front());
                    check("pop_data", inst_data, sb_data.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        lat            = 1;
        sb_pc.delete();
        sb_data.delete();
        acc_addr.delete();
        acc_cyc.delete();
        pop_cyc.delete();
        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        reset = 1'b0;
        rel   = cyc;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 80) begin
            @(negedge clk);
            n++;
            inst_ready = (sb_pc.size() != 0);
            if (sb_pc.size() == 0) break;
        end
        inst_ready = 1'b0;
        if (sb_pc.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d left want 0", name, sb_pc.size());
        end
    endtask

    initial begin
        // Streaming from reset, latency 1
        do_reset();
        #1;
        check("idle_req_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 12; i++) push_exp(32'(4 * i));
        drain("stream");
        check("first_acc_addr", at(acc_addr, 0), 32'h0);
        check("first_acc_cyc", at(acc_cyc, 0), 32'(rel + 1));
        check("first_pop_cyc", at(pop_cyc, 0), 32'(rel + 3));
        check("stream_rate", at(pop_cyc, 11) - at(pop_cyc, 0), 32'd11);

        // Consumer stalled: fill exactly DEPTH entries
        do_reset();
        repeat (12) @(negedge clk);
        check("full_acc_count", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("full_acc_addr", at(acc_addr, i), 32'(4 * i));
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_inst_valid", 32'(inst_valid), 32'd1);
        check("full_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
        drain("full");

        // Redirect with two requests in flight
        do_reset();
        lat = 3;
        push_exp(32'h100);
        push_exp(32'h104);
        push_exp(32'h108);
        repeat (3) @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        drain("redir2");
        check("redir2_acc_addr", at(acc_addr, 2), 32'h100);
        check("redir2_acc_cyc", at(acc_cyc, 2), 32'(rel + 4));

        // Redirect coinciding with a response and an accept
        do_reset();
        push_exp(32'h200);
        push_exp(32'h204);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        drain("redir_same");
        check("same_acc1_addr", at(acc_addr, 1), 32'h4);
        check("same_acc2_addr", at(acc_addr, 2), 32'h200);
        check("same_acc2_cyc", at(acc_cyc, 2), 32'(rel + 3));

        // Redirect while IDLE, then PC wrap past 0xFFFFFFFC
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        push_exp(32'h4);
        @(negedge clk);
        redirect_valid = 1'b0;
        drain("wrap");
        check("wrap_acc0_addr", at(acc_addr, 0), 32'hFFFF_FFFC);
        check("wrap_acc0_cyc", at(acc_cyc, 0), 32'(rel + 1));
        check("wrap_acc1_addr", at(acc_addr, 1), 32'h0);

        // Back-to-back redirects: last target wins
        do_reset();
        imem_req_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_pc    = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        push_exp(32'h400);
        push_exp(32'h404);
        drain("b2b");
        check("b2b_acc_addr", at(acc_addr, 0), 32'h400);

`ifdef IFQ_PERF_EN
        // Perf counters: 5 pops, then flush 3 queued plus 1 in flight
        do_reset();
        lat = 2;
        for (int i = 0; i < 5; i++) push_exp(32'(4 * i));
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            imem_req_ready = (acc_addr.size() < 8);
            inst_ready     = (sb_pc.size() != 0);
            if (acc_addr.size() == 8 && sb_pc.size() == 0 && pend_addr.size() == 0)
                break;
        end
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("perf_head_pc", inst_pc, 32'h14);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_flushed", perf_flushed, 32'd4);
        check("perf_inst_valid", 32'(inst_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
